bioz_clkgen: RTL and testbench

BIOZ_CLKGEN -- requirements
Module: bioz_clkgen

---
 rtl/bioz_pkg.sv | 17 +
 rtl/bioz_clkgen_halfper.sv | 14 +
 rtl/bioz_clkgen.sv | 124 ++++++++++++
 tb/tb_bioz_clkgen.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/bioz_pkg.sv
// Shared constants, state encoding and counter sizing for the BIOZ stimulus clock generator.
package bioz_pkg;

    localparam int FSEL_MAX = 10;
    localparam int FSEL_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Wide enough to hold H = half_div0 << fsel_max itself, not just H-1.
    function automatic int cnt_width(input int half_div0, input int fsel_max);
        return $clog2(half_div0) + fsel_max + 1;
    endfunction

endpackage

// File: rtl/bioz_clkgen_halfper.sv
// Combinational map from a clamped frequency code to the half-period length H.
module bioz_halfper #(
    parameter int HALF_DIV0 = 1024,
    parameter int CNT_W     = 21
) (
    input  logic [bioz_pkg::FSEL_W-1:0] i_fsel,
    output logic [CNT_W-1:0]            o_half_len
);

    always_comb begin
        o_half_len = CNT_W'(HALF_DIV0) << i_fsel;
    end

endmodule

// File: rtl/bioz_clkgen.sv
// Stimulus square-wave generator with period-boundary frequency switching.
// Define BIOZ_QUAD_EN to add the clk_quad output lagging clk_stim by a quarter period.
module bioz_clkgen #(
    parameter int HALF_DIV0 = 1024,
    parameter int FSEL_MAX  = bioz_pkg::FSEL_MAX
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [bioz_pkg::FSEL_W-1:0] fsel,
    output logic                        clk_stim,
`ifdef BIOZ_QUAD_EN
    output logic                        clk_quad,
`endif
    output logic [bioz_pkg::FSEL_W-1:0] fsel_act,
    output logic                        period_done,
    output logic                        running
);

    import bioz_pkg::*;

    // state | meaning
    // IDLE  | outputs low, counter cleared, fsel_act follows clamped fsel
    // RUN   | counting half-periods, clk_stim toggling
    localparam int CNT_W = cnt_width(HALF_DIV0, FSEL_MAX);

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_stim, w_stim_nxt;
    logic                r_pdone, w_pdone_nxt;
    logic [FSEL_W-1:0]   r_fsel_act, w_fsel_act_nxt;
    logic [FSEL_W-1:0]   w_fsel_clamp;
    logic [CNT_W-1:0]    w_half;
    logic                w_half_end;

    bioz_halfper #(
        .HALF_DIV0 (HALF_DIV0),
        .CNT_W     (CNT_W)
    ) u_halfper (
        .i_fsel     (r_fsel_act),
        .o_half_len (w_half)
    );

    assign w_fsel_clamp = (fsel > FSEL_W'(FSEL_MAX)) ? FSEL_W'(FSEL_MAX) : fsel;
    assign w_half_end   = (r_cnt == w_half - CNT_W'(1));

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_stim_nxt     = r_stim;
        w_pdone_nxt    = 1'b0;
        w_fsel_act_nxt = r_fsel_act;
        unique case (r_state)
            IDLE: begin
                w_cnt_nxt      = '0;
                w_stim_nxt     = 1'b0;
                w_fsel_act_nxt = w_fsel_clamp;
                if (enable) begin
                    w_state_nxt = RUN;
                    w_stim_nxt  = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    w_state_nxt    = IDLE;
                    w_cnt_nxt      = '0;
                    w_stim_nxt     = 1'b0;
                    w_fsel_act_nxt = w_fsel_clamp;
                end else if (w_half_end) begin
                    w_cnt_nxt  = '0;
                    w_stim_nxt = ~r_stim;
                    // Rising stim edge closes a full period: only here may the code change.
                    if (!r_stim) begin
                        w_pdone_nxt    = 1'b1;
                        w_fsel_act_nxt = w_fsel_clamp;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_stim     <= 1'b0;
            r_pdone    <= 1'b0;
            r_fsel_act <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_stim     <= w_stim_nxt;
            r_pdone    <= w_pdone_nxt;
            r_fsel_act <= w_fsel_act_nxt;
        end
    end

`ifdef BIOZ_QUAD_EN
    logic r_quad;
    logic w_quad_mid;

    assign w_quad_mid = (r_cnt == (w_half >> 1) - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_quad <= 1'b0;
        end else if (r_state == IDLE || !enable) begin
            r_quad <= 1'b0;
        end else if (w_quad_mid) begin
            r_quad <= ~r_quad;
        end
    end

    assign clk_quad = r_quad;
`endif

    assign clk_stim    = r_stim;
    assign fsel_act    = r_fsel_act;
    assign period_done = r_pdone;
    assign running     = (r_state == RUN);

endmodule

// File: tb/tb_bioz_clkgen.sv
// Scoreboard bench for bioz_clkgen with HALF_DIV0=4; the model tracks position within the full period.
module tb_bioz_clkgen;

    localparam int HD0 = 4;
    localparam int FMX = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] fsel;
    logic       clk_stim;
    logic [3:0] fsel_act;
    logic       period_done;
    logic       running;
`ifdef BIOZ_QUAD_EN
    logic       clk_quad;
`endif

    bioz_clkgen #(
        .HALF_DIV0 (HD0),
        .FSEL_MAX  (FMX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .fsel        (fsel),
        .clk_stim    (clk_stim),
`ifdef BIOZ_QUAD_EN
        .clk_quad    (clk_quad),
`endif
        .fsel_act    (fsel_act),
        .period_done (period_done),
        .running     (running)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       stim;
        logic       quad;
        logic       pd;
        logic       run;
        logic [3:0] code;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   m_run = 1'b0;
    int   m_pos = 0;
    int   m_code = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference: period is 2H cycles, stim high for the first H, quad high from H/2 to 3H/2.
    task automatic model_step(input bit r, input bit e, input logic [3:0] f, output exp_t x);
        int h;
        int fc;
        bit pd;
        pd = 1'b0;
        fc = (int'(f) > FMX) ? FMX : int'(f);
        h  = HD0 << m_code;
        if (r) begin
            m_run = 1'b0; m_pos = 0; m_code = 0;
        end else if (!m_run) begin
            m_code = fc;
            if (e) begin
                m_run = 1'b1; m_pos = 0;
            end
        end else if (!e) begin
            m_run = 1'b0; m_pos = 0; m_code = fc;
        end else begin
            m_pos++;
            if (m_pos == 2 * h) begin
                m_pos = 0; pd = 1'b1; m_code = fc;
            end
        end
        h      = HD0 << m_code;
        x.stim = m_run && (m_pos < h);
        x.quad = m_run && (m_pos >= h / 2) && (m_pos < h + h / 2);
        x.pd   = pd;
        x.run  = m_run;
        x.code = 4'(m_code);
    endtask

    task automatic compare_pending();
        exp_t x;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            chk("clk_stim", 8'(clk_stim), 8'(x.stim));
            chk("period_done", 8'(period_done), 8'(x.pd));
            chk("running", 8'(running), 8'(x.run));
            chk("fsel_act", 8'(fsel_act), 8'(x.code));
`ifdef BIOZ_QUAD_EN
            chk("clk_quad", 8'(clk_quad), 8'(x.quad));
`endif
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [3:0] f);
        exp_t x;
        @(negedge clk);
        compare_pending();
        rst = r; enable = e; fsel = f;
        model_step(r, e, f, x);
        sb_q.push_back(x);
    endtask

    // Advance with enable high until the next posedge will sample the DUT at period position pos.
    task automatic seek(input logic [3:0] f, input int pos);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_run && m_pos == pos) begin
                found = 1'b1;
                break;
            end
            step(1'b0, 1'b1, f);
        end
        chk("seek_position", 8'(found), 8'd1);
    endtask

    initial begin
        logic [3:0] rf;
        rst = 1'b1; enable = 1'b0; fsel = 4'd0;

        repeat (2) step(1'b1, 1'b0, 4'd0);
        repeat (3) step(1'b0, 1'b0, 4'd5);

        // Test A: fsel=0, 8-cycle period
        repeat (24) step(1'b0, 1'b1, 4'd0);

        // Test B: switch to code 2 mid-period
        seek(4'd0, 4);
        repeat (80) step(1'b0, 1'b1, 4'd2);

        // Codes wandering inside periods: only the boundary sample matters
        for (int i = 0; i < 200; i++) begin
            rf = 4'($urandom_range(0, 3));
            step(1'b0, 1'b1, rf);
        end

        // Test D: drop enable at counter=2 of the high half, then restart
        repeat (70) step(1'b0, 1'b1, 4'd0);
        seek(4'd0, 2);
        repeat (4) step(1'b0, 1'b0, 4'd0);
        repeat (10) step(1'b0, 1'b1, 4'd0);
        seek(4'd0, 6);
        step(1'b0, 1'b0, 4'd0);
        repeat (12) step(1'b0, 1'b1, 4'd0);

        // Test F: reset during run overrides enable
        repeat (5) step(1'b0, 1'b1, 4'd3);
        repeat (2) step(1'b1, 1'b1, 4'd3);
        repeat (140) step(1'b0, 1'b1, 4'd3);

        // Test C: out-of-range code clamps to 10 (half-period 4096)
        repeat (2 * 8192 + 100) step(1'b0, 1'b1, 4'd15);

        @(negedge clk);
        compare_pending();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
